// File: rtl/vm2_vic.sv
// ---------------------------------------------------------------------------
// vm2_vic -- vectored interrupt controller in front of the MC1201.02 CPU.
//
// Collects peripheral interrupt requests, raises virq to the CPU, answers the
// CPU istb vector-fetch handshake with the fixed vector of the highest
// priority pending line (line 0 highest), and pulses ackn to the winner.
//
// Ports
//   clk_p  in   1   system clock, rising edge
//   rst_n  in   1   synchronous active-low reset
//   ireq   in   N   peripheral request lines, active-high
//   ien    in   N   per-line enable mask (0 blocks the line)
//   istb   in   1   CPU vector-fetch strobe
//   virq   out  1   vectored interrupt request to the CPU
//   ivec   out  16  vector to the CPU
//   iack   out  1   vector-valid acknowledge to the CPU
//   ackn   out  N   one-cycle acknowledge pulse to the winning peripheral
//   busy   out  1   high while the handshake is not idle
//
// Configuration macro
//   VM2_VIC_EDGE_EN  defined: requests are edge-triggered and held pending
//                    until acknowledged. Undefined (default): pend is a
//                    registered sample of ireq & ien (level mode).
// ---------------------------------------------------------------------------
module vm2_vic #(
   parameter int               N        = 4,
   parameter logic [16*N-1:0]  VECTORS  = {16'o000070, 16'o000064, 16'o000060, 16'o000300},
   parameter logic [15:0]      SPURIOUS = 16'o000000
) (
   input  logic          clk_p,
   input  logic          rst_n,
   input  logic [N-1:0]  ireq,
   input  logic [N-1:0]  ien,
   input  logic          istb,
   output logic          virq,
   output logic [15:0]   ivec,
   output logic          iack,
   output logic [N-1:0]  ackn,
   output logic          busy
);

   localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEL  = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [N-1:0]      pend_q, pend_d;
   logic [SEL_W-1:0]  selr_q, selr_d;
   logic              selv_q, selv_d;
   logic              virq_q, virq_d;
   logic              iack_q, iack_d;
   logic [15:0]       ivec_q, ivec_d;
   logic [N-1:0]      ackn_q, ackn_d;

   logic [SEL_W-1:0]  sel;
   logic [15:0]       sel_vec;
   logic              any_pend;

`ifdef VM2_VIC_EDGE_EN
   logic [N-1:0]      ireq_q;

   // Raw request history for the edge detector; deliberately not reset so a
   // line already high when reset releases is not seen as a fresh edge.
   always_ff @(posedge clk_p) begin
      ireq_q <= ireq;
   end

   // Set on a rising edge, cleared by this line's ackn; set wins a tie.
   // A cleared enable drops the pending bit.
   assign pend_d = ((pend_q & ~ackn_q) | (ireq & ~ireq_q)) & ien;
`else
   assign pend_d = ireq & ien;
`endif

   assign any_pend = |pend_q;

   // Fixed priority: lowest index wins, so scan from the top down.
   always_comb begin
      sel = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (pend_q[i]) sel = SEL_W'(i);
      end
   end

   always_comb begin
      sel_vec = SPURIOUS;
      for (int i = 0; i < N; i++) begin
         if (sel == SEL_W'(i)) sel_vec = VECTORS[16*i +: 16];
      end
   end

   always_comb begin
      state_d = state_q;
      selr_d  = selr_q;
      selv_d  = selv_q;
      ivec_d  = ivec_q;
      iack_d  = iack_q;
      ackn_d  = '0;
      case (state_q)
         S_IDLE: begin
            if (istb) begin
               ivec_d  = any_pend ? sel_vec : SPURIOUS;
               selr_d  = sel;
               selv_d  = any_pend;
               state_d = S_SEL;
            end
         end
         S_SEL: begin
            iack_d = 1'b1;
            for (int i = 0; i < N; i++) begin
               ackn_d[i] = selv_q && (selr_q == SEL_W'(i));
            end
            state_d = S_ACK;
         end
         S_ACK: begin
            if (!istb) begin
               iack_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            iack_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
      // Requiring IDLE both now and next keeps virq low on the accept edge
      // and forces a one-cycle gap after returning from ACK.
      virq_d = any_pend && (state_q == S_IDLE) && (state_d == S_IDLE);
   end

   always_ff @(posedge clk_p) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pend_q  <= '0;
         selr_q  <= '0;
         selv_q  <= 1'b0;
         virq_q  <= 1'b0;
         iack_q  <= 1'b0;
         ivec_q  <= '0;
         ackn_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         selr_q  <= selr_d;
         selv_q  <= selv_d;
         virq_q  <= virq_d;
         iack_q  <= iack_d;
         ivec_q  <= ivec_d;
         ackn_q  <= ackn_d;
      end
   end

   assign virq = virq_q;
   assign ivec = ivec_q;
   assign iack = iack_q;
   assign ackn = ackn_q;
   assign busy = (state_q != S_IDLE);

endmodule
